// File: rtl/gearbox_pkg.sv
// Shared widths, FSM encoding and default sync pattern for the 16-to-20
// gearbox and its downstream word aligner.
package gearbox_pkg;

    localparam int WORD_W = 20;
    localparam int IN_W   = 16;
    localparam int WIN_W  = 2 * WORD_W;
    localparam int IDX_W  = 5;

    localparam logic [WORD_W-1:0] DEFAULT_SYNC_WORD = 20'hFA0C5;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/sync_detect.sv
// Compares every 20-bit candidate of a 40-bit window against the sync word
// and reports the lowest matching bit offset.
module sync_detect
    import gearbox_pkg::*;
(
    input  logic [WIN_W-1:0]  i_window,
    input  logic [WORD_W-1:0] i_sync_word,
    output logic [WORD_W-1:0] o_match,
    output logic              o_any_match,
    output logic [IDX_W-1:0]  o_first_idx
);

    genvar gi;
    generate
        for (gi = 0; gi < WORD_W; gi++) begin : g_cand
            assign o_match[gi] = (i_window[gi +: WORD_W] == i_sync_word);
        end
    endgenerate

    assign o_any_match = |o_match;

    // Scan downwards so the lowest matching offset is the last one written.
    always_comb begin
        o_first_idx = '0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (o_match[i]) begin
                o_first_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/word_aligner.sv
// Hunts for a periodic sync word at any of 20 bit offsets in the gearbox
// output stream, locks onto it and forwards frame-aligned words with SOF.
module word_aligner
    import gearbox_pkg::*;
#(
    parameter logic [WORD_W-1:0] SYNC_WORD = DEFAULT_SYNC_WORD,
    parameter int                FRAME_LEN = 16,
    parameter int                LOCK_CNT  = 3,
    parameter int                LOSS_CNT  = 2
)(
    input  logic              clk,
    input  logic              res_n,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_shift,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_sof,
    output logic              locked
);

    localparam int              CNT_W    = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [3:0]      LOCK_THR = 4'(LOCK_CNT);
    localparam logic [3:0]      LOSS_THR = 4'(LOSS_CNT);

    state_t             r_state, w_state_next;
    logic [WORD_W-1:0]  r_prev;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [3:0]         r_hits, w_hits_next;
    logic [3:0]         r_miss, w_miss_next;
    logic [IDX_W-1:0]   r_off, w_off_next;
    logic               r_out_valid;
    logic               r_out_sof;
    logic [WORD_W-1:0]  r_out_data;

    logic [WIN_W-1:0]   w_window;
    logic [WORD_W-1:0]  w_match;
    logic               w_any_match;
    logic [IDX_W-1:0]   w_first_idx;
    logic               w_shift;
    logic               w_check;
    logic               w_off_hit;
    logic               w_load;
    logic [WORD_W-1:0]  w_aligned;

    assign w_window  = {in_data, r_prev};
    assign w_shift   = res_n & in_valid & (~r_out_valid | out_ready);
    assign w_check   = (r_cnt == CNT_LAST);
    assign w_off_hit = w_match[r_off];
    assign w_aligned = w_window[{1'b0, r_off} +: WORD_W];
    assign w_load    = w_shift && (r_state == LOCKED);

    sync_detect u_sync_detect (
        .i_window    (w_window),
        .i_sync_word (SYNC_WORD),
        .o_match     (w_match),
        .o_any_match (w_any_match),
        .o_first_idx (w_first_idx)
    );

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state <= HUNT;
            r_prev  <= '0;
            r_cnt   <= '0;
            r_hits  <= '0;
            r_miss  <= '0;
            r_off   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_hits  <= w_hits_next;
            r_miss  <= w_miss_next;
            r_off   <= w_off_next;
            if (w_shift) begin
                r_prev <= in_data;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_hits_next  = r_hits;
        w_miss_next  = r_miss;
        w_off_next   = r_off;
        if (w_shift) begin
            w_cnt_next = w_check ? '0 : r_cnt + 1'b1;
            case (r_state)
                HUNT: begin
                    if (w_any_match) begin
                        w_off_next   = w_first_idx;
                        w_cnt_next   = '0;
                        w_hits_next  = 4'd1;
                        w_state_next = VERIFY;
                    end
                end
                VERIFY: begin
                    if (w_check) begin
                        if (!w_off_hit) begin
                            w_state_next = HUNT;
                        end else if (r_hits + 4'd1 >= LOCK_THR) begin
                            w_hits_next  = LOCK_THR;
                            w_miss_next  = '0;
                            w_state_next = LOCKED;
                        end else begin
                            w_hits_next = r_hits + 4'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (w_check) begin
                        if (w_off_hit) begin
                            w_miss_next = '0;
                        end else if (r_miss + 4'd1 >= LOSS_THR) begin
                            w_miss_next  = LOSS_THR;
                            w_state_next = HUNT;
                        end else begin
                            w_miss_next = r_miss + 4'd1;
                        end
                    end
                end
                default: w_state_next = HUNT;
            endcase
        end
    end

    // Output holds under backpressure; a word pending when lock drops still drains.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_data  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_sof   <= w_check;
            r_out_data  <= w_aligned;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
        end
    end

    assign in_shift  = w_shift;
    assign out_valid = r_out_valid;
    assign out_sof   = r_out_sof;
    assign out_data  = r_out_data;
    assign locked    = (r_state == LOCKED);

endmodule

// File: tb/tb_word_aligner.sv
// Randomized bench for word_aligner: stream-level reference model with a
// scoreboard of forwarded words, plus directed checks at frame boundaries.
module tb_word_aligner;

    localparam logic [19:0] SYNC    = 20'hFA0C5;
    localparam logic [19:0] SYNC2   = 20'h6CB65;
    localparam logic [19:0] CORRUPT = 20'h00400;
    localparam int FL   = 16;
    localparam int LOCK = 3;
    localparam int LOSS = 2;

    logic        clk = 1'b0;
    logic        res_n;
    logic        in_valid, in_shift, out_valid, out_ready, out_sof, locked;
    logic [19:0] in_data, out_data;
    logic        in_valid2, in_shift2, out_valid2, out_ready2, out_sof2, locked2;
    logic [19:0] in_data2, out_data2;

    always #5 clk = ~clk;

    word_aligner u_dut (
        .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data),
        .in_shift(in_shift), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sof(out_sof), .locked(locked)
    );

    // Second instance uses a sync word with period 9 so it can match at two offsets at once.
    word_aligner #(.SYNC_WORD(SYNC2)) u_dut2 (
        .clk(clk), .res_n(res_n), .in_valid(in_valid2), .in_data(in_data2),
        .in_shift(in_shift2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_sof(out_sof2), .locked(locked2)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          m_mode, m_off, m_anchor, m_idx, m_hits, m_miss;
    logic [19:0] m_prev;
    logic [20:0] m_q[$];
    logic [19:0] gen  [0:159];
    logic [19:0] gen2 [0:63];

    function automatic int lowest_match(input logic [39:0] w, input logic [19:0] s);
        for (int k = 0; k < 20; k++) begin
            if (w[k +: 20] == s) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_off = 0; m_anchor = 0; m_idx = 0; m_hits = 0; m_miss = 0;
        m_prev = '0;
        m_q.delete();
    endtask

    // Mode 0 hunting, 1 verifying, 2 locked; frame position is measured from the anchor word.
    task automatic model_accept(input logic [19:0] d);
        logic [39:0] w;
        bit          is_check, hit;
        int          k;
        w        = {d, m_prev};
        is_check = (m_mode != 0) && (((m_idx - m_anchor) % FL) == 0);
        hit      = (w[m_off +: 20] == SYNC);
        if (m_mode == 2) m_q.push_back({is_check, w[m_off +: 20]});
        if (m_mode == 0) begin
            k = lowest_match(w, SYNC);
            if (k >= 0) begin
                m_off = k; m_anchor = m_idx; m_hits = 1; m_mode = 1;
            end
        end else if (is_check) begin
            if (m_mode == 1) begin
                if (hit) begin
                    m_hits++;
                    if (m_hits == LOCK) begin m_mode = 2; m_miss = 0; end
                end else begin
                    m_mode = 0;
                end
            end else begin
                if (hit) m_miss = 0;
                else begin
                    m_miss++;
                    if (m_miss == LOSS) m_mode = 0;
                end
            end
        end
        m_prev = d;
        m_idx++;
    endtask

    // One clock of dut1: drive after negedge, check #1 later, update model at posedge.
    task automatic cycle(input logic v, input logic [19:0] d, input logic rdy,
                         output bit acc, output logic sh_dut, output logic [19:0] od);
        bit exp_sh, exp_ov;
        in_valid = v; in_data = d; out_ready = rdy;
        #1;
        exp_ov = (m_q.size() != 0);
        exp_sh = v && (!exp_ov || rdy);
        sh_dut = in_shift;
        od     = out_data;
        n_checks++;
        if (out_valid !== exp_ov) begin
            n_errors++; $display("FAIL out_valid: got %b expected %b", out_valid, exp_ov);
        end
        n_checks++;
        if (in_shift !== exp_sh) begin
            n_errors++; $display("FAIL in_shift: got %b expected %b", in_shift, exp_sh);
        end
        n_checks++;
        if (locked !== (m_mode == 2)) begin
            n_errors++; $display("FAIL locked: got %b expected %b", locked, m_mode == 2);
        end
        if (exp_ov) begin
            n_checks++;
            if ({out_sof, out_data} !== m_q[0]) begin
                n_errors++;
                $display("FAIL out_word: got sof=%b data=%h expected sof=%b data=%h",
                         out_sof, out_data, m_q[0][20], m_q[0][19:0]);
            end
            if (rdy) begin
                $display("xfer data=%h sof=%b", m_q[0][19:0], m_q[0][20]);
                void'(m_q.pop_front());
            end
        end
        @(posedge clk);
        if (exp_sh) model_accept(d);
        acc = exp_sh;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [19:0] d, input int gap, input int rdy_pct);
        bit          acc;
        logic        sh;
        logic [19:0] od;
        int          n;
        for (int g = 0; g < gap; g++)
            cycle(1'b0, 20'($urandom), ($urandom_range(0, 99) < rdy_pct), acc, sh, od);
        acc = 0;
        n   = 0;
        while (!acc && n < 64) begin
            cycle(1'b1, d, ($urandom_range(0, 99) < rdy_pct), acc, sh, od);
            n++;
        end
        n_checks++;
        if (!acc) begin
            n_errors++; $display("FAIL accept_timeout: got no accept expected accept within 64 cycles");
        end
    endtask

    task automatic place(inout logic [19:0] hi, inout logic [19:0] lo,
                         input int off, input logic [19:0] pat);
        logic [39:0] w;
        w = {hi, lo};
        w[off +: 20] = pat;
        hi = w[39:20];
        lo = w[19:0];
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) gen[i] = 20'($urandom);
    endtask

    task automatic do_reset();
        res_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        res_n = 1'b1;
    endtask

    task automatic test_reset();
        bit          acc;
        logic        sh;
        logic [19:0] od;
        res_n = 1'b0; in_valid = 1'b1; in_data = SYNC; out_ready = 1'b1;
        in_valid2 = 1'b1; in_data2 = SYNC2; out_ready2 = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if ({out_valid, out_sof, out_data, locked, in_shift} !== 24'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got v=%b sof=%b d=%h lk=%b sh=%b expected all 0",
                     out_valid, out_sof, out_data, locked, in_shift);
        end
        n_checks++;
        if (in_shift2 !== 1'b0) begin
            n_errors++; $display("FAIL reset_shift2: got %b expected 0", in_shift2);
        end
        in_valid = 1'b0; in_valid2 = 1'b0;
        @(negedge clk);
        res_n = 1'b1;
        cycle(1'b0, '0, 1'b1, acc, sh, od);
        $display("test_reset done");
    endtask

    task automatic test_lock();
        logic [39:0] w;
        fill(60);
        for (int j = 5; j < 60; j += 16) place(gen[j], gen[j-1], 7, SYNC);
        for (int i = 0; i < 60; i++) begin
            send_word(gen[i], 0, 100);
            if (i == 36) begin
                n_checks++;
                if (locked !== 1'b0) begin n_errors++; $display("FAIL lock_early: got %b expected 0", locked); end
            end
            if (i == 37) begin
                n_checks++;
                if (locked !== 1'b1) begin n_errors++; $display("FAIL lock_rise: got %b expected 1", locked); end
            end
            if (i == 38) begin
                w = {gen[38], gen[37]};
                n_checks++;
                if ({out_valid, out_sof, out_data} !== {2'b10, w[26:7]}) begin
                    n_errors++;
                    $display("FAIL first_fwd: got v=%b sof=%b d=%h expected v=1 sof=0 d=%h",
                             out_valid, out_sof, out_data, w[26:7]);
                end
            end
            if (i == 53) begin
                n_checks++;
                if ({out_valid, out_sof, out_data} !== {2'b11, SYNC}) begin
                    n_errors++;
                    $display("FAIL sof_word: got v=%b sof=%b d=%h expected v=1 sof=1 d=%h",
                             out_valid, out_sof, out_data, SYNC);
                end
            end
        end
        $display("test_lock done");
    endtask

    task automatic test_mid_reset();
        bit          acc;
        logic        sh;
        logic [19:0] od;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #2;
        res_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_sof, out_data, locked, in_shift} !== 24'h0) begin
            n_errors++;
            $display("FAIL mid_reset: got v=%b sof=%b d=%h lk=%b sh=%b expected all 0",
                     out_valid, out_sof, out_data, locked, in_shift);
        end
        model_reset();
        @(negedge clk);
        res_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 20'($urandom), 1'b1, acc, sh, od);
        $display("test_mid_reset done");
    endtask

    task automatic test_verify_fail();
        int seen = 0;
        do_reset();
        fill(70);
        place(gen[5], gen[4], 7, SYNC);
        place(gen[21], gen[20], 7, SYNC);
        place(gen[37], gen[36], 7, SYNC ^ CORRUPT);
        for (int i = 0; i < 70; i++) begin
            send_word(gen[i], 0, 100);
            if (out_valid) seen++;
            if (i == 21 || i == 37) begin
                n_checks++;
                if (locked !== 1'b0) begin n_errors++; $display("FAIL verify_locked: got %b expected 0", locked); end
            end
        end
        n_checks++;
        if (seen != 0) begin n_errors++; $display("FAIL verify_no_output: got %0d words expected 0", seen); end
        $display("test_verify_fail done");
    endtask

    task automatic test_loss();
        do_reset();
        fill(125);
        for (int j = 5; j < 125; j += 16)
            place(gen[j], gen[j-1], 7, (j == 69 || j == 101 || j == 117) ? (SYNC ^ CORRUPT) : SYNC);
        for (int i = 0; i < 125; i++) begin
            send_word(gen[i], 0, 100);
            if (i == 69 || i == 85 || i == 101) begin
                n_checks++;
                if (locked !== 1'b1) begin n_errors++; $display("FAIL loss_hold@%0d: got %b expected 1", i, locked); end
            end
            if (i == 117) begin
                n_checks++;
                if ({locked, out_valid, out_sof, out_data} !== {3'b011, SYNC ^ CORRUPT}) begin
                    n_errors++;
                    $display("FAIL loss_drop: got lk=%b v=%b sof=%b d=%h expected lk=0 v=1 sof=1 d=%h",
                             locked, out_valid, out_sof, out_data, SYNC ^ CORRUPT);
                end
            end
        end
        $display("test_loss done");
    endtask

    task automatic test_backpressure();
        bit          acc;
        logic        sh;
        logic [19:0] od, snap;
        int          idx;
        do_reset();
        fill(70);
        for (int j = 5; j < 70; j += 16) place(gen[j], gen[j-1], 11, SYNC);
        for (idx = 0; idx < 46; idx++) send_word(gen[idx], 0, 100);
        snap = m_q[0][19:0];
        for (int c = 1; c <= 5; c++) begin
            cycle(1'b1, gen[idx], 1'b0, acc, sh, od);
            if (acc) idx++;
            if (c >= 2) begin
                n_checks++;
                if (sh !== 1'b0) begin n_errors++; $display("FAIL bp_shift@%0d: got %b expected 0", c, sh); end
                n_checks++;
                if (od !== snap) begin n_errors++; $display("FAIL bp_hold@%0d: got %h expected %h", c, od, snap); end
            end
        end
        for (; idx < 70; idx++) send_word(gen[idx], 0, 100);
        $display("test_backpressure done");
    endtask

    task automatic test_gaps();
        int off;
        do_reset();
        off = $urandom_range(0, 19);
        fill(70);
        for (int j = 4; j < 70; j += 16) place(gen[j], gen[j-1], off, SYNC);
        for (int i = 0; i < 70; i++) begin
            send_word(gen[i], $urandom_range(0, 3), 70);
            if (i == 35 || i == 36) begin
                n_checks++;
                if (locked !== (i == 36)) begin
                    n_errors++; $display("FAIL gaps_lock@%0d: got %b expected %b", i, locked, i == 36);
                end
            end
            if (i == 52) begin
                n_checks++;
                if ({out_valid, out_sof, out_data} !== {2'b11, SYNC}) begin
                    n_errors++;
                    $display("FAIL gaps_sof: got v=%b sof=%b d=%h expected v=1 sof=1 d=%h off=%0d",
                             out_valid, out_sof, out_data, SYNC, off);
                end
            end
        end
        $display("test_gaps done off=%0d", off);
    endtask

    task automatic test_ambiguity();
        logic [39:0] w;
        for (int i = 0; i < 56; i++) gen2[i] = 20'($urandom);
        for (int j = 5; j < 56; j += 16) begin
            place(gen2[j], gen2[j-1], 3, SYNC2);
            place(gen2[j], gen2[j-1], 12, SYNC2);
        end
        out_ready2 = 1'b1;
        for (int i = 0; i < 56; i++) begin
            in_valid2 = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            in_valid2 = 1'b1; in_data2 = gen2[i];
            #1;
            n_checks++;
            if (in_shift2 !== 1'b1) begin n_errors++; $display("FAIL amb_shift@%0d: got %b expected 1", i, in_shift2); end
            @(posedge clk);
            @(negedge clk);
            in_valid2 = 1'b0;
            if (i == 36 || i == 37) begin
                n_checks++;
                if (locked2 !== (i == 37)) begin
                    n_errors++; $display("FAIL amb_lock@%0d: got %b expected %b", i, locked2, i == 37);
                end
            end
            if (i == 38) begin
                w = {gen2[38], gen2[37]};
                n_checks++;
                if ({out_valid2, out_sof2, out_data2} !== {2'b10, w[22:3]}) begin
                    n_errors++;
                    $display("FAIL amb_offset: got v=%b sof=%b d=%h expected v=1 sof=0 d=%h",
                             out_valid2, out_sof2, out_data2, w[22:3]);
                end
            end
            if (i == 53) begin
                n_checks++;
                if ({out_valid2, out_sof2, out_data2} !== {2'b11, SYNC2}) begin
                    n_errors++;
                    $display("FAIL amb_sof: got v=%b sof=%b d=%h expected v=1 sof=1 d=%h",
                             out_valid2, out_sof2, out_data2, SYNC2);
                end
            end
        end
        $display("test_ambiguity done");
    endtask

    initial begin
        test_reset();
        test_lock();
        test_mid_reset();
        test_verify_fail();
        test_loss();
        test_backpressure();
        test_gaps();
        test_ambiguity();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
